// File: rtl/sr_alu_mdu.sv
// RV32I/RV64I integer ALU with M-extension multiply/divide.
// Base ops finish in one cycle; MUL/DIV/REM run radix-2 over XLEN cycles.
module sr_alu_mdu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  input  logic [4:0]      oper,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int SHAMT_W = $clog2(XLEN);

  localparam logic [4:0] ADD  = 5'd0;
  localparam logic [4:0] SUB  = 5'd1;
  localparam logic [4:0] SLL  = 5'd2;
  localparam logic [4:0] SLT  = 5'd3;
  localparam logic [4:0] SLTU = 5'd4;
  localparam logic [4:0] XOR  = 5'd5;
  localparam logic [4:0] SRL  = 5'd6;
  localparam logic [4:0] SRA  = 5'd7;
  localparam logic [4:0] OR   = 5'd8;
  localparam logic [4:0] AND  = 5'd9;
  localparam logic [4:0] MUL  = 5'd10;
  localparam logic [4:0] MULH = 5'd11;
  localparam logic [4:0] MULHSU = 5'd12;
  localparam logic [4:0] MULHU  = 5'd13;
  localparam logic [4:0] DIV  = 5'd14;
  localparam logic [4:0] DIVU = 5'd15;
  localparam logic [4:0] REM  = 5'd16;
  localparam logic [4:0] REMU = 5'd17;

  localparam logic [XLEN-1:0] MIN_NEG =
    {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, nxt;

  logic [4:0]         op;
  logic               is_mul, is_div;
  logic               sgn_a, sgn_b;
  logic               neg_a, neg_b;
  logic [XLEN-1:0]    mag_a, mag_b;
  logic               div0, ovf, go_calc;
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    alu_res;

  logic [4:0]         op_q;
  logic               neg_q, neg_r;
  logic [XLEN-1:0]    m_q;
  logic [2*XLEN-1:0]  acc;
  logic [SHAMT_W-1:0] cnt;
  logic               last;

  logic [XLEN:0]      sum;
  logic [XLEN:0]      sh;
  logic [XLEN-1:0]    rem_n;
  logic               qbit;
  logic [2*XLEN-1:0]  step_n;
  logic [2*XLEN-1:0]  prod;
  logic [XLEN-1:0]    quo, rmd;
  logic [XLEN-1:0]    fin;

  // Reserved opcodes fold onto ADD
  assign op = (oper > REMU) ? ADD : oper;

  assign is_mul = op inside {MUL, MULH, MULHSU, MULHU};
  assign is_div = op inside {DIV, DIVU, REM, REMU};
  assign sgn_a  = op inside {MUL, MULH, MULHSU, DIV, REM};
  assign sgn_b  = op inside {MUL, MULH, DIV, REM};
  assign neg_a  = sgn_a & srcA[XLEN-1];
  assign neg_b  = sgn_b & srcB[XLEN-1];
  assign mag_a  = neg_a ? -srcA : srcA;
  assign mag_b  = neg_b ? -srcB : srcB;

  assign div0 = is_div && (srcB == '0);
  assign ovf  = (op == DIV || op == REM) &&
                (srcA == MIN_NEG) && (srcB == '1);
  assign go_calc = (is_mul | is_div) & ~div0 & ~ovf;
  assign shamt = srcB[SHAMT_W-1:0];

  always_comb begin
    alu_res = '0;
    unique case (1'b1)
      op == ADD:  alu_res = srcA + srcB;
      op == SUB:  alu_res = srcA - srcB;
      op == SLL:  alu_res = srcA << shamt;
      op == SLT:  alu_res = {{(XLEN-1){1'b0}},
                    $signed(srcA) < $signed(srcB)};
      op == SLTU: alu_res = {{(XLEN-1){1'b0}},
                    srcA < srcB};
      op == XOR:  alu_res = srcA ^ srcB;
      op == SRL:  alu_res = srcA >> shamt;
      op == SRA:  alu_res = $signed(srcA) >>> shamt;
      op == OR:   alu_res = srcA | srcB;
      op == AND:  alu_res = srcA & srcB;
      div0:       alu_res = (op == DIV || op == DIVU)
                    ? '1 : srcA;
      ovf:        alu_res = (op == DIV) ? srcA : '0;
      default:    alu_res = '0;
    endcase
  end

  // Shift-add multiply / restoring divide step on magnitudes
  always_comb begin
    sum = {1'b0, acc[2*XLEN-1:XLEN]} +
          (acc[0] ? {1'b0, m_q} : '0);
    sh    = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    qbit  = sh >= {1'b0, m_q};
    rem_n = qbit ? (sh[XLEN-1:0] - m_q) : sh[XLEN-1:0];
    if (op_q inside {DIV, DIVU, REM, REMU})
      step_n = {rem_n, acc[XLEN-2:0], qbit};
    else
      step_n = {sum, acc[XLEN-1:1]};
  end

  always_comb begin
    prod = neg_q ? -step_n : step_n;
    quo  = neg_q ? -step_n[XLEN-1:0] : step_n[XLEN-1:0];
    rmd  = neg_r ? -step_n[2*XLEN-1:XLEN]
                 : step_n[2*XLEN-1:XLEN];
    fin  = '0;
    unique case (1'b1)
      op_q == MUL:               fin = prod[XLEN-1:0];
      op_q inside {DIV, DIVU}:   fin = quo;
      op_q inside {REM, REMU}:   fin = rmd;
      default:                   fin = prod[2*XLEN-1:XLEN];
    endcase
  end

  assign last = (cnt == SHAMT_W'(XLEN-1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (in_valid)
              nxt = go_calc ? CALC : DONE;
      CALC: if (last) nxt = DONE;
      DONE: if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      cnt    <= '0;
      acc    <= '0;
      m_q    <= '0;
      op_q   <= ADD;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          op_q  <= op;
          neg_q <= neg_a ^ neg_b;
          neg_r <= neg_a;
          cnt   <= '0;
          if (go_calc) begin
            m_q <= is_div ? mag_b : mag_a;
            acc <= is_div ? {{XLEN{1'b0}}, mag_a}
                          : {{XLEN{1'b0}}, mag_b};
          end else begin
            result <= alu_res;
          end
        end
        CALC: begin
          acc <= step_n;
          cnt <= cnt + 1'b1;
          if (last) result <= fin;
        end
        default: ;
      endcase
    end
  end

  assign zero = (result == '0);

endmodule

// File: tb/tb_sr_alu_mdu.sv
// Randomized bench for sr_alu_mdu against a plain-arithmetic model.
// Covers XLEN=32 fully and a directed XLEN=16 instance.
module tb_sr_alu_mdu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] srcA, srcB;
  logic [4:0]  oper;
  logic        out_valid, out_ready;
  logic [31:0] result;
  logic        zero;

  logic        h_valid, h_ready;
  logic [15:0] h_a, h_b;
  logic [4:0]  h_op;
  logic        h_ovalid, h_oready;
  logic [15:0] h_res;
  logic        h_zero;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sr_alu_mdu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .srcA(srcA), .srcB(srcB), .oper(oper),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero)
  );

  sr_alu_mdu #(.XLEN(16)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(h_valid), .in_ready(h_ready),
    .srcA(h_a), .srcB(h_b), .oper(h_op),
    .out_valid(h_ovalid), .out_ready(h_oready),
    .result(h_res), .zero(h_zero)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref32(
    input int op, input logic [31:0] a,
    input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    logic        ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      1:  return a - b;
      2:  return a << b[4:0];
      3:  return {31'd0, sa < sb};
      4:  return {31'd0, a < b};
      5:  return a ^ b;
      6:  return a >> b[4:0];
      7:  return $signed(a) >>> b[4:0];
      8:  return a | b;
      9:  return a & b;
      10: begin p = sa * sb; return p[31:0]; end
      11: begin p = sa * sb; return p[63:32]; end
      12: begin p = sa * ub; return p[63:32]; end
      13: begin p = ua * ub; return p[63:32]; end
      14: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      15: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      16: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      17: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
      default: return a + b;
    endcase
  endfunction

  function automatic int lat32(
    input int op, input logic [31:0] a,
    input logic [31:0] b);
    if (op >= 10 && op <= 13) return 33;
    if (op >= 14 && op <= 17) begin
      if (b == 0) return 1;
      if ((op == 14 || op == 16) &&
          a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
        return 1;
      return 33;
    end
    return 1;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  task automatic run(input int op,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input int stall);
    logic [31:0] exp;
    logic [31:0] held;
    int lat;
    logic busy_rdy;
    exp = ref32(op, a, b);
    @(negedge clk);
    check("idle_rdy", in_ready, 1);
    in_valid = 1; srcA = a; srcB = b;
    oper = 5'(op);
    @(posedge clk); #1;
    srcA = $urandom; srcB = $urandom;
    oper = 5'($urandom);
    in_valid = $urandom_range(0, 1);
    lat = 1;
    busy_rdy = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_rdy = 1;
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, lat32(op, a, b));
    check("busy_rdy", busy_rdy, 0);
    check($sformatf("res_op%0d", op), result, exp);
    check("zero", zero, exp == 0);
    held = result;
    in_valid = (stall > 0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("hold_res", result, held);
      check("hold_vld", out_valid, 1);
      check("hold_rdy", in_ready, 0);
      srcA = $urandom; srcB = $urandom;
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    in_valid = 0;
    check("hs_vld", out_valid, 0);
    check("hs_rdy", in_ready, 1);
  endtask

  task automatic run16(input int op,
                       input logic [15:0] a,
                       input logic [15:0] b,
                       input logic [15:0] exp,
                       input int elat);
    int lat;
    @(negedge clk);
    h_valid = 1; h_a = a; h_b = b; h_op = 5'(op);
    @(posedge clk); #1;
    h_valid = 0; h_a = '0; h_b = '0;
    lat = 1;
    while (!h_ovalid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("lat16", lat, elat);
    check("res16", h_res, exp);
    h_oready = 1;
    @(posedge clk); #1;
    h_oready = 0;
    check("hs16", h_ovalid, 0);
  endtask

  initial begin
    rst = 1; in_valid = 0; out_ready = 0;
    srcA = 0; srcB = 0; oper = 0;
    h_valid = 0; h_oready = 0;
    h_a = 0; h_b = 0; h_op = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check("rst_vld", out_valid, 0);
    check("rst_res", result, 0);
    check("rst_rdy", in_ready, 1);

    run(0,  32'h7FFF_FFFF, 32'd1, 0);
    run(1,  32'd5, 32'd5, 0);
    run(7,  32'h8000_0000, 32'h24, 0);
    run(3,  32'hFFFF_FFFF, 32'd1, 0);
    run(4,  32'hFFFF_FFFF, 32'd1, 0);
    run(13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run(10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run(11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run(12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run(14, 32'hFFFF_FFF9, 32'd2, 0);
    run(16, 32'hFFFF_FFF9, 32'd2, 0);
    run(15, 32'd100, 32'd7, 0);
    run(17, 32'd100, 32'd7, 0);
    run(14, 32'd5, 32'd0, 0);
    run(16, 32'd5, 32'd0, 0);
    run(14, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run(16, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run(25, 32'd2, 32'd3, 0);
    run(15, 32'd1000, 32'd7, 10);

    @(negedge clk);
    in_valid = 1; oper = 5'd14;
    srcA = 32'd100; srcB = 32'd7;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (12) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    rst = 0;
    check("abort_vld", out_valid, 0);
    check("abort_res", result, 0);
    check("abort_rdy", in_ready, 1);
    run(0, 32'd2, 32'd3, 0);

    for (int i = 0; i < 200; i++)
      run($urandom_range(0, 31), pick(), pick(),
          ($urandom_range(0, 7) == 0) ? 2 : 0);

    run16(13, 16'hFFFF, 16'hFFFF, 16'hFFFE, 17);
    run16(2,  16'h0001, 16'h0013, 16'h0008, 1);
    run16(14, 16'hFFF9, 16'h0002, 16'hFFFD, 17);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
